// File: rtl/con_ff_pkg.sv
// Shared condition-code constants and FSM state type for the conditional-branch flip-flop unit.
package con_ff_pkg;

  localparam logic [2:0] CondEqZero = 3'b000;
  localparam logic [2:0] CondNeZero = 3'b001;
  localparam logic [2:0] CondGeZero = 3'b010;
  localparam logic [2:0] CondLtZero = 3'b011;
  localparam logic [2:0] CondGtZero = 3'b100;
  localparam logic [2:0] CondLeZero = 3'b101;
  localparam logic [2:0] CondAlways = 3'b110;
  localparam logic [2:0] CondNever  = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StHold = 2'd2
  } con_state_e;

endpackage

// File: rtl/con_cond_eval.sv
// Combinational branch-condition evaluator: 3-bit condition code applied to a signed operand.
module con_cond_eval
  import con_ff_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        i_code,
  input  logic [DATA_W-1:0] i_operand,
  output logic              o_decision
);

  logic w_zero;
  logic w_sign;

  assign w_zero = (i_operand == '0);
  assign w_sign = i_operand[DATA_W-1];

  always_comb begin
    o_decision = 1'b0;
    case (i_code)
      CondEqZero: o_decision = w_zero;
      CondNeZero: o_decision = !w_zero;
      CondGeZero: o_decision = !w_sign;
      CondLtZero: o_decision = w_sign;
      CondGtZero: o_decision = !w_sign && !w_zero;
      CondLeZero: o_decision = w_sign || w_zero;
      CondAlways: o_decision = 1'b1;
      CondNever:  o_decision = 1'b0;
      default:    o_decision = 1'b0;
    endcase
  end

endmodule

// File: rtl/con_ff_unit.sv
// Registered branch-decision unit: captures operands on a ConIn rising edge and evaluates next cycle.
// Define CON_BRANCH_STATS_EN to build the saturating taken-branch counter on TakenCount.
module con_ff_unit
  import con_ff_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned COND_LSB = 19,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              ConIn,
  input  logic              ConClr,
  input  logic [31:0]       IRout,
  input  logic [DATA_W-1:0] BusMuxOut,
  output logic              ConFFOut,
  output logic              ConValid,
  output logic              ConBusy,
  output logic [CNT_W-1:0]  TakenCount
);

  con_state_e        r_state, w_state_nxt;
  logic              r_conin_d;
  logic [2:0]        r_code, w_code_nxt;
  logic [DATA_W-1:0] r_operand, w_operand_nxt;
  logic              r_ff, w_ff_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_req;
  logic              w_decision;
  logic              w_taken_evt;
  logic              w_unused_ir;

  assign w_req       = ConIn && !r_conin_d;
  assign w_unused_ir = ^IRout;

  con_cond_eval #(
    .DATA_W(DATA_W)
  ) u_cond_eval (
    .i_code    (r_code),
    .i_operand (r_operand),
    .o_decision(w_decision)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_operand_nxt = r_operand;
    w_ff_nxt      = r_ff;
    w_valid_nxt   = r_valid;
    w_taken_evt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // ConClr has priority over a coincident request edge
        if (!ConClr && w_req) begin
          w_code_nxt    = IRout[COND_LSB +: 3];
          w_operand_nxt = BusMuxOut;
          w_state_nxt   = StEval;
        end
      end
      StEval: begin
        if (ConClr) begin
          w_state_nxt = StIdle;
          w_ff_nxt    = 1'b0;
          w_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = StHold;
          w_ff_nxt    = w_decision;
          w_valid_nxt = 1'b1;
          w_taken_evt = w_decision;
        end
      end
      StHold: begin
        if (ConClr) begin
          w_state_nxt = StIdle;
          w_ff_nxt    = 1'b0;
          w_valid_nxt = 1'b0;
        end else if (w_req) begin
          // Re-evaluation: old decision stays visible on ConFFOut until EVAL completes
          w_code_nxt    = IRout[COND_LSB +: 3];
          w_operand_nxt = BusMuxOut;
          w_valid_nxt   = 1'b0;
          w_state_nxt   = StEval;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_ff_nxt    = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= StIdle;
      r_conin_d <= 1'b0;
      r_code    <= '0;
      r_operand <= '0;
      r_ff      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_conin_d <= ConIn;
      r_code    <= w_code_nxt;
      r_operand <= w_operand_nxt;
      r_ff      <= w_ff_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign ConFFOut = r_ff;
  assign ConValid = r_valid;
  assign ConBusy  = (r_state == StEval);

`ifdef CON_BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_taken <= '0;
    end else if (w_taken_evt && (r_taken != '1)) begin
      r_taken <= r_taken + CNT_W'(1);
    end
  end

  assign TakenCount = r_taken;
`else
  logic w_unused_taken;
  assign w_unused_taken = w_taken_evt;
  assign TakenCount     = '0;
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed self-checking bench for con_ff_unit; expected TakenCount follows CON_BRANCH_STATS_EN.
module tb_con_ff_unit;

  logic        clock;
  logic        clear;
  logic        ConIn;
  logic        ConClr;
  logic [31:0] IRout;
  logic [31:0] BusMuxOut;
  logic        ConFFOut;
  logic        ConValid;
  logic        ConBusy;
  logic [1:0]  TakenCount;

  int n_checks;
  int n_pass;
  int taken_n;
  int busy_cnt;
  logic prev_ff;

`ifdef CON_BRANCH_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  con_ff_unit #(
    .DATA_W  (32),
    .COND_LSB(19),
    .CNT_W   (2)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .ConIn     (ConIn),
    .ConClr    (ConClr),
    .IRout     (IRout),
    .BusMuxOut (BusMuxOut),
    .ConFFOut  (ConFFOut),
    .ConValid  (ConValid),
    .ConBusy   (ConBusy),
    .TakenCount(TakenCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_taken();
    if (!StatsOn) return 32'd0;
    return (taken_n > 3) ? 32'd3 : 32'(taken_n);
  endfunction

  // Issue one request edge, check the EVAL cycle, then the registered decision.
  task automatic do_eval(input logic [2:0] code, input logic [31:0] op, input logic exp);
    IRout     = 32'(code) << 19;
    BusMuxOut = op;
    ConIn     = 1'b1;
    @(negedge clock);
    check_val("eval_busy", 32'(ConBusy), 32'd1);
    check_val("eval_valid", 32'(ConValid), 32'd0);
    check_val("eval_ff_kept", 32'(ConFFOut), 32'(prev_ff));
    ConIn = 1'b0;
    @(negedge clock);
    check_val("dec_ff", 32'(ConFFOut), 32'(exp));
    check_val("dec_valid", 32'(ConValid), 32'd1);
    check_val("dec_busy", 32'(ConBusy), 32'd0);
    prev_ff = exp;
    if (exp) taken_n++;
    check_val("taken_cnt", 32'(TakenCount), exp_taken());
  endtask

  logic [2:0]  v_code [10];
  logic [31:0] v_op   [10];
  logic        v_exp  [10];

  initial begin
    n_checks = 0; n_pass = 0; taken_n = 0; prev_ff = 1'b0;
    clear = 1'b1; ConIn = 1'b0; ConClr = 1'b0; IRout = '0; BusMuxOut = '0;

    v_code = '{3'b000, 3'b100, 3'b100, 3'b101, 3'b111,
               3'b001, 3'b010, 3'b011, 3'b000, 3'b110};
    v_op   = '{32'h0, 32'h0, 32'h5, 32'h8000_0000, 32'h1234,
               32'h7, 32'h8000_0000, 32'h8000_0000, 32'h3, 32'hFFFF_FFFF};
    v_exp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    #2;
    check_val("rst_ff", 32'(ConFFOut), 32'd0);
    check_val("rst_valid", 32'(ConValid), 32'd0);
    check_val("rst_busy", 32'(ConBusy), 32'd0);
    check_val("rst_taken", 32'(TakenCount), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) do_eval(v_code[i], v_op[i], v_exp[i]);

    // HOLD ignores operand changes without a new edge
    BusMuxOut = 32'hFFFF_FFFF;
    IRout     = 32'(3'b111) << 19;
    repeat (3) begin
      @(negedge clock);
      check_val("hold_ff", 32'(ConFFOut), 32'd1);
      check_val("hold_valid", 32'(ConValid), 32'd1);
    end

    // ConIn held high for 10 cycles gives exactly one evaluation
    IRout = 32'(3'b000) << 19; BusMuxOut = 32'h0; ConIn = 1'b1;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (ConBusy) busy_cnt++;
    end
    check_val("held_once", 32'(busy_cnt), 32'd1);
    check_val("held_ff", 32'(ConFFOut), 32'd1);
    ConIn = 1'b0; taken_n++;
    @(negedge clock);

    // ConClr coincident with a request edge wins; held ConIn never fires later
    ConClr = 1'b1; ConIn = 1'b1;
    @(negedge clock);
    check_val("clr_ff", 32'(ConFFOut), 32'd0);
    check_val("clr_valid", 32'(ConValid), 32'd0);
    check_val("clr_busy", 32'(ConBusy), 32'd0);
    ConClr = 1'b0;
    busy_cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (ConBusy || ConValid) busy_cnt++;
    end
    check_val("clr_no_eval", 32'(busy_cnt), 32'd0);
    ConIn = 1'b0; prev_ff = 1'b0;
    @(negedge clock);

    // ConClr during EVAL aborts the evaluation
    IRout = 32'(3'b110) << 19; ConIn = 1'b1;
    @(negedge clock);
    check_val("abort_busy", 32'(ConBusy), 32'd1);
    ConClr = 1'b1; ConIn = 1'b0;
    @(negedge clock);
    check_val("abort_ff", 32'(ConFFOut), 32'd0);
    check_val("abort_valid", 32'(ConValid), 32'd0);
    check_val("abort_busy_off", 32'(ConBusy), 32'd0);
    check_val("abort_taken", 32'(TakenCount), exp_taken());
    ConClr = 1'b0;
    @(negedge clock);

    // Async clear mid-EVAL, then a ConIn already high is a fresh edge
    do_eval(3'b110, 32'h0, 1'b1);
    ConIn = 1'b1;
    @(negedge clock);
    check_val("aclr_pre_busy", 32'(ConBusy), 32'd1);
    #2 clear = 1'b1;
    #1;
    check_val("aclr_ff", 32'(ConFFOut), 32'd0);
    check_val("aclr_valid", 32'(ConValid), 32'd0);
    check_val("aclr_busy", 32'(ConBusy), 32'd0);
    check_val("aclr_taken", 32'(TakenCount), 32'd0);
    taken_n = 0;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check_val("post_clr_busy", 32'(ConBusy), 32'd1);
    ConIn = 1'b0;
    @(negedge clock);
    check_val("post_clr_ff", 32'(ConFFOut), 32'd1);
    check_val("post_clr_valid", 32'(ConValid), 32'd1);
    taken_n = 1;
    check_val("post_clr_taken", 32'(TakenCount), exp_taken());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/con_ff_unit.md
CON_FF_UNIT -- requirements
Module: con_ff_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of BusMuxOut and of the condition operand.
REQ-002 Parameter COND_LSB, default 19: bit position of the condition-field LSB in IRout.
REQ-003 Parameter CNT_W, default 16: width of TakenCount.
REQ-004 clock  in  1: single clock, all state updates on rising edge.
REQ-005 clear  in  1: reset, asynchronous, active-high.
REQ-006 ConIn  in  1: evaluate request, level signal; rising edge sampled synchronously.
REQ-007 ConClr  in  1: synchronous clear of the latched branch decision.
REQ-008 IRout  in  32: instruction register; condition field IRout[COND_LSB+2:COND_LSB].
REQ-009 BusMuxOut  in  DATA_W: operand under test.
REQ-010 ConFFOut  out  1: registered branch decision.
REQ-011 ConValid  out  1: ConFFOut holds a decision for the current request.
REQ-012 ConBusy  out  1: evaluation in progress (state EVAL).
REQ-013 TakenCount  out  CNT_W: count of taken decisions (see Configuration).

Function
REQ-014 Condition codes (3-bit): 000 =0; 001 !=0; 010 >=0 (sign bit clear); 011 <0 (sign bit set); 100 >0 (sign clear and nonzero); 101 <=0 (sign set or zero); 110 always; 111 never. Signed tests use BusMuxOut[DATA_W-1].
REQ-015 Request edge = ConIn==1 at a clock edge where registered ConIn_d==0; ConIn held high does not re-trigger.
REQ-016 FSM states IDLE, EVAL, HOLD.
REQ-017 IDLE: ConFFOut=0, ConValid=0; on request edge, capture condition field and BusMuxOut into internal registers, go to EVAL.
REQ-018 EVAL (exactly one cycle): ConBusy=1, ConValid=0, ConFFOut keeps previous value; next edge writes ConFFOut from captured operands, sets ConValid=1, goes to HOLD.
REQ-019 Latency: request edge sampled at edge k -> ConFFOut/ConValid updated at edge k+1.
REQ-020 HOLD: ConFFOut and ConValid stable; BusMuxOut/IRout changes ignored.
REQ-021 HOLD + request edge: capture new operands, go to EVAL (re-evaluation).
REQ-022 ConClr in HOLD or EVAL: next edge -> IDLE, ConFFOut=0, ConValid=0, capture aborted.
REQ-023 ConClr and request edge same cycle: ConClr wins; request discarded; ConIn_d still updates, so held ConIn does not fire later.
REQ-024 Request edge during EVAL: ignored (only one request per EVAL).

Reset
REQ-025 clear asserted: immediately state=IDLE, ConFFOut=0, ConValid=0, ConBusy=0, ConIn_d=0, captured registers=0, TakenCount=0.
REQ-026 clear mid-EVAL aborts evaluation; no counter increment.
REQ-027 After clear deasserts, ConIn already high is seen as a request edge at the first clock edge.

Configuration
REQ-028 Macro CON_BRANCH_STATS_EN defined: TakenCount increments by 1 at each EVAL->HOLD transition with decision 1; saturates at all-ones; cleared only by clear.
REQ-029 Macro undefined: no counter logic; TakenCount tied to 0; all other behaviour identical.

Structure
REQ-030 Package con_ff_pkg holds the 3-bit condition-code constants and the FSM state typedef.
REQ-031 Sub-module con_cond_eval: combinational (code, operand) -> decision, parametrised by DATA_W; instantiated once on the captured registers.

Verification
REQ-032 Code 000, BusMuxOut=0, ConIn pulse -> ConBusy=1 one cycle, then ConFFOut=1, ConValid=1 the next cycle.
REQ-033 Code 100 with 0x00000000 -> 0; with 0x00000005 -> 1; code 101 with 0x80000000 -> 1; code 111 with any value -> 0.
REQ-034 In HOLD with ConFFOut=1, change BusMuxOut to 0xFFFFFFFF without a new edge -> ConFFOut stays 1; ConIn held high 10 cycles -> exactly one evaluation.
REQ-035 ConClr and ConIn rise same cycle -> IDLE, ConFFOut=0, ConValid=0, no evaluation; clear asserted during EVAL -> outputs 0 asynchronously.
REQ-036 With CON_BRANCH_STATS_EN, CNT_W=2: 5 taken evaluations -> TakenCount=3 (saturated); with macro undefined -> TakenCount=0.
